// File: rtl/dist_pkg.sv
// dist_pkg: shared constants, field offsets and transmit state encoding for the frame packer
package dist_pkg;
  localparam logic [7:0] HDR0_B = 8'hA5;
  localparam logic [7:0] HDR1_B = 8'h5A;
  localparam int HDR_LEN = 6;
  localparam int BYTES_PER_PT = 4;
  localparam int DIST_MSB = 31;
  localparam int RSSI_MSB = 15;
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_HDR  = 4'b0010,
    ST_BODY = 4'b0100,
    ST_CSUM = 4'b1000
  } tx_state_e;
endpackage

// File: rtl/dist_pp_ram.sv
// dist_pp_ram: two-bank simple dual-port point RAM, address {bank, index}, registered read
module dist_pp_ram #(
  parameter int AW = 3
) (
  input  logic          i_clk_50m,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(1<<AW)-1];
  always_ff @(posedge i_clk_50m) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/dist_frame_packer.sv
// dist_frame_packer: ping-pong buffers distance points into frames and streams them as checksummed byte packets
module dist_frame_packer
  import dist_pkg::*;
#(
  parameter int         FRAME_PTS = 90,
  parameter logic [7:0] HDR0      = HDR0_B,
  parameter logic [7:0] HDR1      = HDR1_B
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_dist_sig,
  input  logic [15:0] i_code_angle,
  input  logic [63:0] i_edge_data,
  input  logic        i_zero_sign,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_sof,
  output logic        o_tx_eof,
  input  logic        i_tx_ready,
  output logic        o_drop_pulse,
  output logic        o_busy
);
  localparam int IW = FRAME_PTS > 1 ? $clog2(FRAME_PTS) : 1;
  logic [1:0] full;
  logic [7:0] cnt [2];
  logic [15:0] sa [2];
  logic wr_bank, rd_ptr, close, wb, accept, last, acc, rel, stale;
  logic [7:0] wr_cnt, wc_eff, pt, cnt_l, seq, csum, hdr_byte, body_byte;
  logic [15:0] ang_l;
  logic [2:0] idx;
  logic [31:0] rdata;
  logic unused_rise_fall;
  tx_state_e st, st_n;
  assign unused_rise_fall = ^i_edge_data[63:32];
  assign close = i_zero_sign && wr_cnt != 8'd0;
  assign wb = close ? !wr_bank : wr_bank;
  assign wc_eff = close ? 8'd0 : wr_cnt;
  assign accept = i_dist_sig && !full[wb];
  assign last = accept && wc_eff == 8'(FRAME_PTS - 1);
  dist_pp_ram #(.AW(IW + 1)) u_ram (
    .i_clk_50m(i_clk_50m),
    .we(accept && !i_rst),
    .waddr({wb, wc_eff[IW-1:0]}),
    .wdata(i_edge_data[DIST_MSB:0]),
    .raddr({rd_ptr, pt[IW-1:0]}),
    .rdata(rdata)
  );
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      full <= 2'b00;
      wr_bank <= 1'b0;
      wr_cnt <= 8'd0;
      o_drop_pulse <= 1'b0;
    end else begin
      o_drop_pulse <= i_dist_sig && !accept;
      if (rel) full[rd_ptr] <= 1'b0;
      if (close) begin
        full[wr_bank] <= 1'b1;
        cnt[wr_bank] <= wr_cnt;
      end
      if (accept && wc_eff == 8'd0) sa[wb] <= i_code_angle;
      if (last) begin
        full[wb] <= 1'b1;
        cnt[wb] <= 8'(FRAME_PTS);
        wr_bank <= !wb;
        wr_cnt <= 8'd0;
      end else if (accept) begin
        wr_bank <= wb;
        wr_cnt <= wc_eff + 8'd1;
      end else if (close) begin
        wr_bank <= !wr_bank;
        wr_cnt <= 8'd0;
      end
    end
  end
  assign acc = o_tx_valid && i_tx_ready;
  assign rel = st == ST_CSUM && acc;
  always_comb begin
    st_n = st;
    if (st == ST_IDLE && full[rd_ptr]) st_n = ST_HDR;
    if (acc && st == ST_HDR && idx == 3'(HDR_LEN - 1)) st_n = ST_BODY;
    if (acc && st == ST_BODY && idx == 3'(BYTES_PER_PT - 1) && pt == cnt_l - 8'd1) st_n = ST_CSUM;
    if (rel) st_n = ST_IDLE;
  end
  assign hdr_byte = idx == 3'd0 ? HDR0 : idx == 3'd1 ? HDR1 : idx == 3'd2 ? seq :
                    idx == 3'd3 ? cnt_l : idx == 3'd4 ? ang_l[15:8] : ang_l[7:0];
  assign body_byte = idx == 3'd0 ? rdata[DIST_MSB-:8] : idx == 3'd1 ? rdata[DIST_MSB-8-:8] :
                     idx == 3'd2 ? rdata[RSSI_MSB-:8] : rdata[RSSI_MSB-8-:8];
  assign o_tx_valid = st == ST_HDR || st == ST_CSUM || (st == ST_BODY && !stale);
  assign o_tx_data = st == ST_HDR ? hdr_byte : (st == ST_BODY && !stale) ? body_byte :
                     st == ST_CSUM ? csum : 8'd0;
  assign o_tx_sof = st == ST_HDR && idx == 3'd0;
  assign o_tx_eof = st == ST_CSUM;
  assign o_busy = |full || st != ST_IDLE;
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      st <= ST_IDLE;
      rd_ptr <= 1'b0;
      seq <= 8'd0;
      idx <= 3'd0;
      pt <= 8'd0;
      csum <= 8'd0;
      stale <= 1'b0;
      cnt_l <= 8'd0;
      ang_l <= 16'd0;
    end else begin
      st <= st_n;
      stale <= 1'b0;
      if (st == ST_IDLE) begin
        idx <= 3'd0;
        pt <= 8'd0;
        csum <= 8'd0;
        cnt_l <= cnt[rd_ptr];
        ang_l <= sa[rd_ptr];
      end
      if (acc) begin
        csum <= csum ^ o_tx_data;
        idx <= (st == ST_HDR ? idx == 3'(HDR_LEN - 1) : idx == 3'(BYTES_PER_PT - 1)) ? 3'd0 : idx + 3'd1;
      end
      if (acc && st == ST_BODY && idx == 3'(BYTES_PER_PT - 1)) begin
        pt <= pt + 8'd1;
        stale <= 1'b1;
      end
      if (rel) begin
        seq <= seq + 8'd1;
        rd_ptr <= !rd_ptr;
      end
    end
  end
endmodule
